dcache_line_responder: RTL and testbench
========================================

# dcache_line_responder

Memory-side responder for the data cache's line refill and writeback traffic. It accepts one line-granular request at a time from the DCache miss path. Reads return a burst of `LINE_BEATS` 64-bit beats after a programmable wait. Writes absorb `LINE_BEATS` masked beats and return a one-cycle acknowledge. It sits below the DCache in the simulation SoC as the backing store and protocol checker for the cache's downstream port.

## Interface
Parameters:
- `LINE_BEATS`, 4: 64-bit beats per cache line; power of two, 2..16.
- `MEM_WORDS`, 1024: 64-bit words of backing storage; power of two.
- `LATENCY`, 2: idle cycles between request acceptance and first read beat / first WdataReady; 0..15.

Ports (clock and reset first):
- `Clk` in 1: single clock, all logic rising-edge.
- `Rst` in 1: synchronous, active-high reset.
- `ReqValid` in 1: request present.
- `ReqReady` out 1: responder can accept a request.
- `ReqWrite` in 1: 1 = writeback, 0 = refill.
- `ReqAddr` in `AddrBus`: byte address; offset bits below line size ignored.
- `WdataValid` in 1: write beat present.
- `WdataReady` out 1: write beat accepted when both high.
- `Wdata` in `DataBus`: write beat data.
- `Wmask` in 8: per-byte write enable, bit i covers `Wdata[8i+7:8i]`.
- `RdataValid` out 1: read beat present.
- `RdataReady` in 1: read beat consumed when both high.
- `Rdata` out `DataBus`: read beat data.
- `RdataLast` out 1: marks final beat of a refill.
- `WackValid` out 1: one-cycle pulse, writeback committed.

## Operation
- States: IDLE, WAIT, RBURST, WBURST, WACK.
- IDLE: `ReqReady`=1; on `ReqValid`, latch line base index and `ReqWrite`, load wait counter with `LATENCY`. Go to WAIT, or straight to RBURST/WBURST if `LATENCY`=0.
- Line base index = `ReqAddr[3 +: log2(MEM_WORDS)]` with low log2(`LINE_BEATS`) bits cleared. Addresses beyond storage wrap modulo `MEM_WORDS`.
- WAIT: decrement counter; at 0 go to RBURST or WBURST by latched `ReqWrite`.
- RBURST: `RdataValid`=1 with `Rdata` = mem[base+beat]. Beat counter advances only on `RdataValid && RdataReady`. `RdataLast`=1 when beat = `LINE_BEATS`-1. Handshake on last beat -> IDLE.
- WBURST: `WdataReady`=1. On each handshake, bytes with `Wmask` set are written to mem[base+beat], others kept; beat advances. Handshake on last beat -> WACK.
- WACK: `WackValid`=1 for exactly one cycle -> IDLE.
- Beats are always in ascending order from line base; no critical-word-first, no wrap within a line.
- `WdataValid` outside WBURST is ignored; no data is written.

## Timing
- Reset values: `ReqReady`=0 during the reset cycle, then 1 (IDLE); `RdataValid`, `RdataLast`, `WdataReady`, `WackValid`=0; `Rdata`=0. State=IDLE, counters=0. Storage contents are not cleared.
- Request accepted at edge T: first read beat valid in the cycle after edge T+`LATENCY`. Unstalled refill occupies `LATENCY`+`LINE_BEATS` cycles, then `ReqReady` returns the next cycle.
- `Rdata`/`RdataLast`/`RdataValid` hold stable while `RdataValid` && !`RdataReady`.
- Writeback with no stalls: `WackValid` in the cycle after the last write handshake.
- Back-to-back: a request may be accepted in the first IDLE cycle after a burst or WACK.
- A write to word W followed by a refill covering W returns the merged data.
- `Rst` asserted in any state aborts the transaction. Partially written beats stay written; no `WackValid` is issued.

## Structure
- `AddrBus`/`DataBus` come from the shared defines. Add shared defines for line beats, the state encoding and mask width, which the DCache miss path also uses.
- One sub-module, `dcache_resp_mem`: `MEM_WORDS`x64 array with one read port and one byte-masked write port. Read is combinational from the registered beat index. Write is synchronous.

## Test plan
- Preload mem[0..3]=0x11..,0x22..,0x33..,0x44..; refill `ReqAddr`=0x10, `RdataReady`=1. Expected: 4 beats in order, `RdataLast` on beat 3, first beat `LATENCY`+1 cycles after acceptance.
- Refill with `RdataReady` toggled 1,0,0,1,... Expected: each beat held stable while stalled; no beat skipped or repeated.
- Writeback to 0x40, `Wmask`=0x0F on beat 1 over prior 0xFFFF_FFFF_FFFF_FFFF. Expected: `WackValid` one cycle after beat 3, then a refill returns beat 1 = 0xFFFF_FFFF_xxxx_xxxx merged.
- `ReqAddr` = `MEM_WORDS`*8 + 0x20. Expected: wraps to index 4; data equals mem[4..7].
- Assert `Rst` during beat 2 of a refill. Expected: all outputs 0 the next cycle, then `ReqReady`=1. A new request completes normally.
- `LATENCY`=0 build, back-to-back write then read. Expected: `WdataReady` the cycle after acceptance; read accepted in the first cycle after `WackValid`.

Source files
------------

// File: rtl/dcache_line_responder_pkg.sv
// dcache_line_responder_pkg: bus types, line geometry and state encoding shared with the DCache miss path
package dcache_line_responder_pkg;

    typedef logic [31:0] AddrBus;
    typedef logic [63:0] DataBus;

    localparam int DefaultLineBeats = 4;
    localparam int MaskWidth = 8;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StRburst,
        StWburst,
        StWack
    } RespState;

endpackage

// File: rtl/dcache_resp_mem.sv
// dcache_resp_mem: MEM_WORDS x 64 backing store, combinational read, synchronous byte-masked write
// Ports: Clk; RdIdx -> RdData (combinational); WrEn/WrIdx/WrData/WrMask write on rising Clk.
module dcache_resp_mem
    import dcache_line_responder_pkg::*;
#(
    parameter int MEM_WORDS = 1024
) (
    input  logic                         Clk,
    input  logic [$clog2(MEM_WORDS)-1:0] RdIdx,
    output DataBus                       RdData,
    input  logic                         WrEn,
    input  logic [$clog2(MEM_WORDS)-1:0] WrIdx,
    input  DataBus                       WrData,
    input  logic [MaskWidth-1:0]         WrMask
);

    DataBus mem [MEM_WORDS];

    assign RdData = mem[RdIdx];

    always_ff @(posedge Clk)
        if (WrEn)
            for (int i = 0; i < MaskWidth; i++)
                if (WrMask[i]) mem[WrIdx][8*i +: 8] <= WrData[8*i +: 8];

endmodule

// File: rtl/dcache_line_responder.sv
// dcache_line_responder: line-granular refill/writeback responder with programmable latency
// Ports: Clk, Rst (sync, active-high); request ReqValid/ReqReady/ReqWrite/ReqAddr;
// write beats WdataValid/WdataReady/Wdata/Wmask; read beats RdataValid/RdataReady/Rdata/RdataLast;
// WackValid one-cycle writeback commit pulse.
module dcache_line_responder
    import dcache_line_responder_pkg::*;
#(
    parameter int LINE_BEATS = DefaultLineBeats,
    parameter int MEM_WORDS  = 1024,
    parameter int LATENCY    = 2
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 ReqValid,
    output logic                 ReqReady,
    input  logic                 ReqWrite,
    input  AddrBus               ReqAddr,
    input  logic                 WdataValid,
    output logic                 WdataReady,
    input  DataBus               Wdata,
    input  logic [MaskWidth-1:0] Wmask,
    output logic                 RdataValid,
    input  logic                 RdataReady,
    output DataBus               Rdata,
    output logic                 RdataLast,
    output logic                 WackValid
);

    localparam int IdxW = $clog2(MEM_WORDS);
    localparam int BeatW = $clog2(LINE_BEATS);
    localparam logic [BeatW-1:0] LastBeat = BeatW'(LINE_BEATS - 1);
    // WAIT spans LATENCY cycles, so the counter leaves on reaching zero
    localparam logic [3:0] WaitLoad = 4'(LATENCY == 0 ? 0 : LATENCY - 1);

    RespState          state;
    logic [IdxW-1:0]   base;
    logic [BeatW-1:0]  beat;
    logic [3:0]        waitCnt;
    logic              isWrite;
    logic [IdxW-1:0]   memIdx;
    DataBus            memData;
    logic              unusedAddr;

    // base has its beat bits cleared, so OR is the in-line offset with no carry
    assign memIdx = base | IdxW'(beat);
    assign Rdata = RdataValid ? memData : '0;
    assign unusedAddr = ^{ReqAddr[2:0], ReqAddr >> (IdxW + 3)};

    dcache_resp_mem #(.MEM_WORDS(MEM_WORDS)) mem (
        .Clk    (Clk),
        .RdIdx  (memIdx),
        .RdData (memData),
        .WrEn   (WdataValid && WdataReady && !Rst),
        .WrIdx  (memIdx),
        .WrData (Wdata),
        .WrMask (Wmask)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= StIdle;
            base       <= '0;
            beat       <= '0;
            waitCnt    <= '0;
            isWrite    <= 1'b0;
            ReqReady   <= 1'b0;
            RdataValid <= 1'b0;
            RdataLast  <= 1'b0;
            WdataReady <= 1'b0;
            WackValid  <= 1'b0;
        end else begin
            case (state)
                StIdle:
                    if (ReqValid && ReqReady) begin
                        ReqReady <= 1'b0;
                        base     <= ReqAddr[3 +: IdxW] & ~IdxW'(LINE_BEATS - 1);
                        isWrite  <= ReqWrite;
                        waitCnt  <= WaitLoad;
                        if (LATENCY == 0) begin
                            state      <= ReqWrite ? StWburst : StRburst;
                            WdataReady <= ReqWrite;
                            RdataValid <= !ReqWrite;
                        end else
                            state <= StWait;
                    end else
                        ReqReady <= 1'b1;
                StWait:
                    if (waitCnt == 4'd0) begin
                        state      <= isWrite ? StWburst : StRburst;
                        WdataReady <= isWrite;
                        RdataValid <= !isWrite;
                    end else
                        waitCnt <= waitCnt - 1'b1;
                StRburst:
                    if (RdataReady) begin
                        beat      <= beat + 1'b1;
                        RdataLast <= (beat + 1'b1 == LastBeat);
                        if (beat == LastBeat) begin
                            state      <= StIdle;
                            RdataValid <= 1'b0;
                            RdataLast  <= 1'b0;
                            ReqReady   <= 1'b1;
                        end
                    end
                StWburst:
                    if (WdataValid) begin
                        beat <= beat + 1'b1;
                        if (beat == LastBeat) begin
                            state      <= StWack;
                            WdataReady <= 1'b0;
                            WackValid  <= 1'b1;
                        end
                    end
                StWack: begin
                    state     <= StIdle;
                    WackValid <= 1'b0;
                    ReqReady  <= 1'b1;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_line_responder.sv
// tb_dcache_line_responder: directed checks of refill, writeback, wrap, abort and zero-latency behaviour
module tb_dcache_line_responder;
    import dcache_line_responder_pkg::*;

    logic   Clk = 1'b0;
    logic   Rst = 1'b1;
    logic   ReqValid = 1'b0, ReqReady, ReqWrite = 1'b0;
    AddrBus ReqAddr = '0;
    logic   WdataValid = 1'b0, WdataReady;
    DataBus Wdata = '0;
    logic [7:0] Wmask = '0;
    logic   RdataValid, RdataReady = 1'b0, RdataLast, WackValid;
    DataBus Rdata;

    logic   ReqValidZ = 1'b0, ReqReadyZ, ReqWriteZ = 1'b0;
    AddrBus ReqAddrZ = '0;
    logic   WdataValidZ = 1'b0, WdataReadyZ;
    DataBus WdataZ = '0;
    logic [7:0] WmaskZ = '0;
    logic   RdataValidZ, RdataReadyZ = 1'b0, RdataLastZ, WackValidZ;
    DataBus RdataZ;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    dcache_line_responder #(.LINE_BEATS(4), .MEM_WORDS(1024), .LATENCY(2)) dut (
        .Clk(Clk), .Rst(Rst), .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
        .ReqAddr(ReqAddr), .WdataValid(WdataValid), .WdataReady(WdataReady), .Wdata(Wdata),
        .Wmask(Wmask), .RdataValid(RdataValid), .RdataReady(RdataReady), .Rdata(Rdata),
        .RdataLast(RdataLast), .WackValid(WackValid)
    );

    dcache_line_responder #(.LINE_BEATS(4), .MEM_WORDS(1024), .LATENCY(0)) dutZ (
        .Clk(Clk), .Rst(Rst), .ReqValid(ReqValidZ), .ReqReady(ReqReadyZ), .ReqWrite(ReqWriteZ),
        .ReqAddr(ReqAddrZ), .WdataValid(WdataValidZ), .WdataReady(WdataReadyZ), .Wdata(WdataZ),
        .Wmask(WmaskZ), .RdataValid(RdataValidZ), .RdataReady(RdataReadyZ), .Rdata(RdataZ),
        .RdataLast(RdataLastZ), .WackValid(WackValidZ)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic request(input AddrBus addr, input logic wr);
        int n;
        n = 0;
        while (!ReqReady && n < 50) begin
            @(negedge Clk);
            n++;
        end
        check("req_ready_wait", 64'(ReqReady), 64'(1));
        ReqValid = 1'b1;
        ReqWrite = wr;
        ReqAddr = addr;
        @(negedge Clk);
        ReqValid = 1'b0;
    endtask

    task automatic writeLine(input AddrBus addr, input logic [255:0] d, input logic [31:0] m);
        int n;
        request(addr, 1'b1);
        for (int b = 0; b < 4; b++) begin
            WdataValid = 1'b1;
            Wdata = d[64*b +: 64];
            Wmask = m[8*b +: 8];
            n = 0;
            while (!WdataReady && n < 50) begin
                @(negedge Clk);
                n++;
            end
            check("wdata_ready", 64'(WdataReady), 64'(1));
            if (b == 0) check("wr_latency", 64'(n), 64'(2));
            @(negedge Clk);
        end
        WdataValid = 1'b0;
        check("wack_pulse", 64'(WackValid), 64'(1));
        @(negedge Clk);
        check("wack_drop", 64'(WackValid), 64'(0));
        check("idle_after_wb", 64'(ReqReady), 64'(1));
    endtask

    task automatic readLine(input AddrBus addr, input logic [255:0] d, input logic [7:0] pat);
        int beat, cyc, first, k;
        request(addr, 1'b0);
        beat = 0;
        cyc = 1;
        first = 0;
        k = 0;
        while (beat < 4 && cyc < 100) begin
            if (RdataValid) begin
                if (first == 0) first = cyc;
                check("rdata", Rdata, d[64*beat +: 64]);
                check("rlast", 64'(RdataLast), 64'(beat == 3));
                RdataReady = pat[k % 8];
                k++;
                if (RdataReady) beat++;
            end else
                RdataReady = 1'b0;
            @(negedge Clk);
            cyc++;
        end
        RdataReady = 1'b0;
        check("beats_done", 64'(beat), 64'(4));
        check("first_beat_latency", 64'(first), 64'(3));
        check("rvalid_drop", 64'(RdataValid), 64'(0));
        check("idle_after_rd", 64'(ReqReady), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] base0, ones, merged, wrap;
        int n;
        base0 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        ones = {4{64'hFFFF_FFFF_FFFF_FFFF}};
        merged = {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
                  64'hFFFF_FFFF_89AB_CDEF, 64'hA0A0_A0A0_A0A0_A0A0};
        wrap = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};

        repeat (2) @(negedge Clk);
        check("rst_req_ready", 64'(ReqReady), 64'(0));
        check("rst_rvalid", 64'(RdataValid), 64'(0));
        check("rst_rlast", 64'(RdataLast), 64'(0));
        check("rst_wready", 64'(WdataReady), 64'(0));
        check("rst_wack", 64'(WackValid), 64'(0));
        check("rst_rdata", Rdata, 64'h0);
        check("rst_req_ready_z", 64'(ReqReadyZ), 64'(0));
        Rst = 1'b0;
        @(negedge Clk);
        check("post_rst_ready", 64'(ReqReady), 64'(1));

        writeLine(32'h0, base0, 32'hFFFF_FFFF);
        readLine(32'h10, base0, 8'hFF);
        readLine(32'h0, base0, 8'h99);

        writeLine(32'h40, ones, 32'hFFFF_FFFF);
        writeLine(32'h40, {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
                           64'h0123_4567_89AB_CDEF, 64'hA0A0_A0A0_A0A0_A0A0}, 32'hFFFF_0FFF);
        readLine(32'h40, merged, 8'hFF);

        writeLine(32'h20, wrap, 32'hFFFF_FFFF);
        readLine(32'h2020, wrap, 8'hFF);

        WdataValid = 1'b1;
        Wdata = 64'hDEAD_BEEF_DEAD_BEEF;
        Wmask = 8'hFF;
        repeat (3) @(negedge Clk);
        WdataValid = 1'b0;

        request(32'h0, 1'b0);
        RdataReady = 1'b1;
        n = 0;
        while (!RdataValid && n < 20) begin
            @(negedge Clk);
            n++;
        end
        repeat (2) @(negedge Clk);
        check("abort_beat2", Rdata, 64'h3333_3333_3333_3333);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        RdataReady = 1'b0;
        check("abort_req_ready", 64'(ReqReady), 64'(0));
        check("abort_rvalid", 64'(RdataValid), 64'(0));
        check("abort_rlast", 64'(RdataLast), 64'(0));
        check("abort_rdata", Rdata, 64'h0);
        check("abort_wready", 64'(WdataReady), 64'(0));
        check("abort_wack", 64'(WackValid), 64'(0));
        @(negedge Clk);
        check("abort_ready_back", 64'(ReqReady), 64'(1));
        readLine(32'h0, base0, 8'hFF);

        check("z_idle_ready", 64'(ReqReadyZ), 64'(1));
        ReqValidZ = 1'b1;
        ReqWriteZ = 1'b1;
        ReqAddrZ = 32'h100;
        @(negedge Clk);
        ReqValidZ = 1'b0;
        check("z_wready_first", 64'(WdataReadyZ), 64'(1));
        for (int b = 0; b < 4; b++) begin
            WdataValidZ = 1'b1;
            WdataZ = 64'hC0DE_0000_0000_0000 | 64'(b);
            WmaskZ = 8'hFF;
            check("z_wready", 64'(WdataReadyZ), 64'(1));
            @(negedge Clk);
        end
        WdataValidZ = 1'b0;
        check("z_wack", 64'(WackValidZ), 64'(1));
        ReqValidZ = 1'b1;
        ReqWriteZ = 1'b0;
        @(negedge Clk);
        check("z_wack_drop", 64'(WackValidZ), 64'(0));
        check("z_ready_after_wack", 64'(ReqReadyZ), 64'(1));
        @(negedge Clk);
        ReqValidZ = 1'b0;
        RdataReadyZ = 1'b1;
        for (int b = 0; b < 4; b++) begin
            check("z_rvalid", 64'(RdataValidZ), 64'(1));
            check("z_rdata", RdataZ, 64'hC0DE_0000_0000_0000 | 64'(b));
            check("z_rlast", 64'(RdataLastZ), 64'(b == 3));
            @(negedge Clk);
        end
        RdataReadyZ = 1'b0;
        check("z_rvalid_drop", 64'(RdataValidZ), 64'(0));
        check("z_idle_again", 64'(ReqReadyZ), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
